img_stream_src: RTL and testbench

Parametrised pixel source that streams one of several stored images, pixel by pixel, from an external synchronous ROM into the inference pipeline. Image size, pixel width, image count and inter-pixel gap are parameters. The gap is a runtime value. Consumers can apply back-pressure through a valid/ready handshake. Frame markers, abort and completion/error status are provided. It replaces the fixed 28×28, fixed-interval, no-back-pressure image feeder at the head of the accelerator datapath.

---
 rtl/img_stream_src.sv | 161 ++++++++++++++++
 tb/tb_img_stream_src.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_src.sv
// Streams one stored image, pixel by pixel, from a synchronous ROM onto a
// valid/ready pixel port with frame markers, abort and done/err status.
module img_stream_src #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int NUM_IMGS = 4,
    parameter int SEL_W    = 2,
    parameter int ADDR_W   = 12,
    parameter int GAP_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  img_sel,
    input  logic [GAP_W-1:0]  gap,
    input  logic              abort,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] pix_dout,
    output logic              pix_vld,
    input  logic              pix_rdy,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [2:0]        state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ADDR_W-1:0] base;
    logic              sel_ok;
    logic              last_pix;

    assign state_dbg = state;
    assign sel_ok    = 32'(img_sel) < 32'(NUM_IMGS);
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

    // Image base is a mux of constants, so the address path needs no multiplier.
    always_comb begin
        base = '0;
        for (int i = 0; i < NUM_IMGS; i++) begin
            if (32'(img_sel) == 32'(i)) base = ADDR_W'(i * IMG_W * IMG_H);
        end
    end

    // Pixel port: a pixel transfers on a rising edge where pix_vld && pix_rdy;
    // once pix_vld is raised, pix_dout and the flags stay put until that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row      <= '0;
            col      <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            pix_dout <= '0;
            pix_vld  <= 1'b0;
            sof      <= 1'b0;
            eol      <= 1'b0;
            eof      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rom_en <= 1'b0;
            if (abort) begin
                state   <= S_IDLE;
                pix_vld <= 1'b0;
                sof     <= 1'b0;
                eol     <= 1'b0;
                eof     <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (sel_ok) begin
                                gap_q    <= gap;
                                rom_addr <= base;
                                row      <= '0;
                                col      <= '0;
                                busy     <= 1'b1;
                                rom_en   <= 1'b1;
                                state    <= S_FETCH;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: state <= S_WAIT;
                    S_WAIT: begin
                        pix_dout <= rom_dout;
                        pix_vld  <= 1'b1;
                        sof      <= (row == '0) && (col == '0);
                        eol      <= (col == COL_LAST);
                        eof      <= last_pix;
                        state    <= S_OUT;
                    end
                    S_OUT: begin
                        if (pix_rdy) begin
                            pix_vld <= 1'b0;
                            sof     <= 1'b0;
                            eol     <= 1'b0;
                            eof     <= 1'b0;
                            if (last_pix) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                if (col == COL_LAST) begin
                                    col <= '0;
                                    row <= row + 1'b1;
                                end else begin
                                    col <= col + 1'b1;
                                end
                                if (gap_q != '0) begin
                                    gap_cnt <= gap_q - 1'b1;
                                    state   <= S_GAP;
                                end else begin
                                    rom_en <= 1'b1;
                                    state  <= S_FETCH;
                                end
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            rom_en <= 1'b1;
                            state  <= S_FETCH;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_img_stream_src.sv
// Bench for img_stream_src: small 4x3 images, ROM word i holds value i; pixel
// stream, timing and status are compared against a frame-level model.
module tb_img_stream_src;
    localparam int DATA_W   = 8;
    localparam int IMG_W    = 4;
    localparam int IMG_H    = 3;
    localparam int NUM_IMGS = 2;
    localparam int SEL_W    = 2;
    localparam int ADDR_W   = 6;
    localparam int GAP_W    = 4;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int W        = DATA_W + 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              pix_rdy;
    logic [SEL_W-1:0]  img_sel;
    logic [GAP_W-1:0]  gap_in;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic [DATA_W-1:0] pix_dout;
    logic              pix_vld, sof, eol, eof, busy, done, err;
    logic [2:0]        state_dbg;
    logic [DATA_W-1:0] rom_mem [2**ADDR_W];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rom_cnt = 0, busy_cnt = 0, err_cnt = 0, done_cnt = 0, stall_cnt = 0, hs_cnt = 0;
    int cur_gap = 0, last_hs_cyc = 0, last_eof_cyc = 0, first_sof_cyc = 0, stalls_pix = 0;
    bit prev_stall = 0, prev_rom_en = 0, hs_live = 0;
    logic [W-1:0] held;
    logic [W-1:0] exp_q[$];

    typedef struct {
        int sel;
        int g;
        bit rnd;
        bit bad;
        int exp_busy;
    } vec_t;
    vec_t vecs[7];

    img_stream_src #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_IMGS(NUM_IMGS),
        .SEL_W(SEL_W), .ADDR_W(ADDR_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_sel(img_sel), .gap(gap_in),
        .abort(abort), .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .pix_dout(pix_dout), .pix_vld(pix_vld), .pix_rdy(pix_rdy), .sof(sof),
        .eol(eol), .eof(eof), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
    );

    // clock / reset and ROM model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (rom_en) rom_dout <= rom_mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is every pixel of the image in raster order.
    task automatic push_frame(input int sel);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                exp_q.push_back({DATA_W'(sel * NPIX + r * IMG_W + c), r == 0 && c == 0,
                                 c == IMG_W - 1, r == IMG_H - 1 && c == IMG_W - 1});
            end
        end
    endtask

    // Scoreboard / monitor, evaluated once per cycle on the falling edge.
    task automatic sample();
        logic [W-1:0] act;
        logic [W-1:0] e;
        act = {pix_dout, sof, eol, eof};
        if (!rst_n) begin
            prev_stall  = 0;
            prev_rom_en = 0;
            hs_live     = 0;
            stalls_pix  = 0;
            return;
        end
        if (prev_rom_en) chk("rom_en_single_cycle", 32'(rom_en), 0);
        prev_rom_en = rom_en;
        if (rom_en) rom_cnt++;
        if (busy) busy_cnt++;
        if (err) err_cnt++;
        if (done) begin
            done_cnt++;
            chk("busy_in_done_cycle", 32'(busy), 0);
            chk("done_after_last_pixel", cyc - last_hs_cyc, 1);
        end
        if (prev_stall) begin
            chk("held_vld", 32'(pix_vld), 1);
            chk("held_pixel", 32'(act), 32'(held));
        end
        prev_stall = pix_vld && !pix_rdy;
        if (prev_stall) begin
            stall_cnt++;
            stalls_pix++;
            held = act;
        end
        if (pix_vld && pix_rdy) begin
            hs_cnt++;
            chk("pixel_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pixel_value_flags", 32'(act), 32'(e));
            end
            if (hs_live) chk("pixel_spacing", cyc - last_hs_cyc, 3 + cur_gap + stalls_pix);
            stalls_pix  = 0;
            last_hs_cyc = cyc;
            if (sof) first_sof_cyc = cyc;
            if (eof) last_eof_cyc = cyc;
            hs_live = !eof;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_frame(input int sel, input int g, input bit rnd, input bit bad,
                             input int exp_busy);
        int rom0, busy0, err0, done0, stall0, hs0, lat, n;
        rom0 = rom_cnt; busy0 = busy_cnt; err0 = err_cnt;
        done0 = done_cnt; stall0 = stall_cnt; hs0 = hs_cnt;
        if (!bad) push_frame(sel);
        cur_gap = g;
        img_sel = SEL_W'(sel);
        gap_in  = GAP_W'(g);
        pix_rdy = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        if (bad) begin
            chk("err_pulse", 32'(err), 1);
            chk("busy_on_reject", 32'(busy), 0);
            repeat (6) step();
            chk("err_count", err_cnt - err0, 1);
            chk("rom_on_reject", rom_cnt - rom0, 0);
            chk("busy_cycles_reject", busy_cnt - busy0, exp_busy);
            return;
        end
        lat = 1;
        while (!pix_vld && lat < 20) begin
            if (rnd) pix_rdy = $urandom_range(0, 3) != 0;
            step();
            lat++;
        end
        chk("first_pixel_latency", lat, 3);
        n = 0;
        while (done_cnt == done0 && n < 3000) begin
            if (rnd) pix_rdy = $urandom_range(0, 3) != 0;
            step();
            n++;
        end
        pix_rdy = 1'b1;
        step();
        chk("frame_done", done_cnt - done0, 1);
        chk("frame_pixels", hs_cnt - hs0, NPIX);
        chk("frame_rom_reads", rom_cnt - rom0, NPIX);
        chk("frame_busy_cycles", busy_cnt - busy0, exp_busy + (stall_cnt - stall0));
        chk("frame_queue_empty", exp_q.size(), 0);
        chk("frame_no_err", err_cnt - err0, 0);
    endtask

    initial begin
        int n, hs0, done0, err0, stall0, rom_snap, a_eof, sel, g;
        vecs[0] = '{1, 0, 1'b0, 1'b0, 36};
        vecs[1] = '{0, 5, 1'b0, 1'b0, 91};
        vecs[2] = '{1, 2, 1'b0, 1'b0, 58};
        vecs[3] = '{2, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{3, 7, 1'b0, 1'b1, 0};
        vecs[5] = '{0, 15, 1'b0, 1'b0, 201};
        vecs[6] = '{1, 1, 1'b1, 1'b0, 47};
        for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'(i);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix_rdy = 1'b1;
        img_sel = '0; gap_in = '0;
        repeat (3) step();
        chk("reset_outputs", 32'({pix_dout, pix_vld, sof, eol, eof, rom_en, rom_addr,
                                  busy, done, err}), 0);
        chk("reset_state", 32'(state_dbg), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].sel, vecs[i].g, vecs[i].rnd, vecs[i].bad, vecs[i].exp_busy);

        // back-pressure: pixel 5 of image 1 held for 7 cycles, mid-frame start ignored
        hs0 = hs_cnt; err0 = err_cnt; stall0 = stall_cnt; done0 = done_cnt;
        push_frame(1);
        cur_gap = 0; gap_in = '0; img_sel = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (hs_cnt - hs0 < 5 && n < 200) begin step(); n++; end
        step();
        pix_rdy = 1'b0; start = 1'b1; img_sel = 2'd3;
        step();
        start = 1'b0;
        chk("bp_vld", 32'(pix_vld), 1);
        chk("bp_data", 32'(pix_dout), 17);
        chk("bp_flags", 32'({sof, eol, eof}), 0);
        repeat (7) step();
        chk("bp_data_end", 32'(pix_dout), 17);
        pix_rdy = 1'b1;
        n = 0;
        while (done_cnt == done0 && n < 200) begin step(); n++; end
        step();
        chk("bp_pixels", hs_cnt - hs0, NPIX);
        chk("bp_stalls", stall_cnt - stall0, 7);
        chk("bp_no_err", err_cnt - err0, 0);
        chk("bp_queue_empty", exp_q.size(), 0);

        // abort in WAIT of pixel 6, together with a start request
        hs0 = hs_cnt; done0 = done_cnt;
        push_frame(1);
        img_sel = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (hs_cnt - hs0 < 6 && n < 200) begin step(); n++; end
        step();
        abort = 1'b1; start = 1'b1; img_sel = 2'd0;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abort_vld", 32'(pix_vld), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rom_en_flags", 32'({rom_en, sof, eol, eof}), 0);
        rom_snap = rom_cnt;
        repeat (5) step();
        chk("abort_no_done", done_cnt - done0, 0);
        chk("abort_no_fetch", rom_cnt - rom_snap, 0);
        chk("abort_pixels_seen", hs_cnt - hs0, 6);
        exp_q.delete();
        hs_live = 0; stalls_pix = 0;
        run_frame(0, 0, 1'b0, 1'b0, 36);

        // chaining: second start lands in the done cycle of the first frame
        done0 = done_cnt;
        push_frame(0);
        img_sel = 2'd0; gap_in = '0; cur_gap = 0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin step(); n++; end
        chk("chain_done_seen", 32'(done), 1);
        chk("chain_busy_low", 32'(busy), 0);
        a_eof = last_eof_cyc;
        push_frame(1);
        img_sel = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("chain_accepted", 32'(busy), 1);
        n = 0;
        while (done_cnt - done0 < 2 && n < 200) begin step(); n++; end
        step();
        chk("chain_no_lost_cycle", first_sof_cyc - a_eof, 4);
        chk("chain_done_count", done_cnt - done0, 2);
        chk("chain_queue_empty", exp_q.size(), 0);

        // randomized frames, including rejected selects
        for (int k = 0; k < 8; k++) begin
            sel = $urandom_range(0, 3);
            g   = $urandom_range(0, 3);
            if (sel >= NUM_IMGS) run_frame(sel, g, 1'b1, 1'b1, 0);
            else run_frame(sel, g, 1'b1, 1'b0, 3 * NPIX + (NPIX - 1) * g);
        end

        // asynchronous reset while a pixel is held in OUT
        push_frame(0);
        img_sel = 2'd0; gap_in = '0; start = 1'b1;
        step();
        start = 1'b0; pix_rdy = 1'b0;
        n = 0;
        while (!pix_vld && n < 20) begin step(); n++; end
        chk("pre_reset_vld", 32'(pix_vld), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_out", 32'({pix_dout, pix_vld, sof, eol, eof, rom_en, rom_addr,
                                  busy, done, err}), 0);
        chk("reset_mid_out_state", 32'(state_dbg), 0);
        exp_q.delete();
        pix_rdy = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        run_frame(1, 1, 1'b0, 1'b0, 47);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
